// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one asynchronous 8-bit SRAM between a CPU port (read/write) and a
// video fetch port (read-only). Arbitration happens only while IDLE. Video
// normally wins, but after MAX_VIDEO_RUN consecutive video grants made while
// the CPU was waiting, the CPU is served next.
//
// Every SRAM pin is registered, so the address is stable for the whole access
// and the write strobe can never overlap an address change.
//
// Ports
//   clk_chipset   system clock, all logic on its rising edge
//   rst_n         synchronous active-low reset
//   cpu_req/we/addr/wdata  CPU request level and access parameters (sampled at grant)
//   cpu_rdata     CPU read data, updated with cpu_ack on reads and held
//   cpu_ack       one-cycle completion pulse for the CPU
//   vid_req/addr  video fetch request level and address (sampled at grant)
//   vid_rdata     video read data, updated with vid_ack and held
//   vid_ack       one-cycle completion pulse for video
//   SRAM_ADDR, SRAM_WE_n, sram_d_out, sram_d_oe   registered SRAM controls
//   sram_d_in     SRAM data bus input
//   busy          high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,   // cycles the address is held per access, 2..15
    parameter int MAX_VIDEO_RUN = 4    // video grants allowed while the CPU waits, 1..15
) (
    input  logic        clk_chipset,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [20:0] vid_addr,
    output logic [7:0]  vid_rdata,
    output logic        vid_ack,
    output logic [20:0] SRAM_ADDR,
    output logic        SRAM_WE_n,
    input  logic [7:0]  sram_d_in,
    output logic [7:0]  sram_d_out,
    output logic        sram_d_oe,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

    localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES);
    localparam logic [3:0] RUN_MAX  = 4'(MAX_VIDEO_RUN);

    state_t      state_reg;
    logic [3:0]  cnt_reg;        // cycle index within READ/WRITE, starts at 1
    logic [3:0]  vid_run_reg;
    logic        owner_cpu_reg;  // which port the current read belongs to
    logic [20:0] sram_addr_reg;
    logic        sram_we_n_reg;
    logic [7:0]  sram_d_out_reg;
    logic        sram_d_oe_reg;
    logic [7:0]  cpu_rdata_reg;
    logic [7:0]  vid_rdata_reg;
    logic        cpu_ack_reg;
    logic        vid_ack_reg;

    logic cpu_eligible;
    logic grant_vid;
    logic grant_cpu;

    // The CPU holds its request until it sees the ack, so a request seen in
    // the ack cycle is the one just served and must not be granted again.
    // Video is a streaming fetch level: every cycle it is high is a fresh
    // request, which is what lets video reads run back-to-back.
    always_comb begin
        cpu_eligible = cpu_req && !cpu_ack_reg;
        grant_vid    = 1'b0;
        grant_cpu    = 1'b0;
        if (state_reg == IDLE) begin
            if (vid_req && (!cpu_eligible || (vid_run_reg != RUN_MAX))) begin
                grant_vid = 1'b1;
            end else if (cpu_eligible) begin
                grant_cpu = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_chipset) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            vid_run_reg    <= 4'd0;
            owner_cpu_reg  <= 1'b0;
            sram_addr_reg  <= 21'd0;
            sram_we_n_reg  <= 1'b1;
            sram_d_out_reg <= 8'd0;
            sram_d_oe_reg  <= 1'b0;
            cpu_rdata_reg  <= 8'd0;
            vid_rdata_reg  <= 8'd0;
            cpu_ack_reg    <= 1'b0;
            vid_ack_reg    <= 1'b0;
        end else begin
            cpu_ack_reg <= 1'b0;
            vid_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sram_we_n_reg <= 1'b1;
                    sram_d_oe_reg <= 1'b0;
                    if (grant_cpu || !cpu_req) begin
                        vid_run_reg <= 4'd0;
                    end else if (grant_vid && (vid_run_reg != RUN_MAX)) begin
                        vid_run_reg <= vid_run_reg + 4'd1;
                    end
                    if (grant_vid) begin
                        state_reg     <= READ;
                        owner_cpu_reg <= 1'b0;
                        sram_addr_reg <= vid_addr;
                        cnt_reg       <= 4'd1;
                    end else if (grant_cpu) begin
                        owner_cpu_reg <= 1'b1;
                        sram_addr_reg <= cpu_addr;
                        cnt_reg       <= 4'd1;
                        if (cpu_we) begin
                            // Drive data from the first cycle; the strobe
                            // follows one cycle later so the bus is settled.
                            state_reg      <= WRITE;
                            sram_d_out_reg <= cpu_wdata;
                            sram_d_oe_reg  <= 1'b1;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt_reg == ACC_LAST) begin
                        state_reg <= IDLE;
                        if (owner_cpu_reg) begin
                            cpu_rdata_reg <= sram_d_in;
                            cpu_ack_reg   <= 1'b1;
                        end else begin
                            vid_rdata_reg <= sram_d_in;
                            vid_ack_reg   <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                WRITE: begin
                    if (cnt_reg == ACC_LAST) begin
                        // Release the strobe one cycle before the bus so the
                        // data stays valid across the write-enable rising edge.
                        state_reg     <= TURN;
                        sram_we_n_reg <= 1'b1;
                    end else begin
                        cnt_reg       <= cnt_reg + 4'd1;
                        sram_we_n_reg <= 1'b0;
                    end
                end
                TURN: begin
                    state_reg     <= IDLE;
                    sram_d_oe_reg <= 1'b0;
                    cpu_ack_reg   <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    sram_we_n_reg <= 1'b1;
                    sram_d_oe_reg <= 1'b0;
                end
            endcase
        end
    end

    assign SRAM_ADDR  = sram_addr_reg;
    assign SRAM_WE_n  = sram_we_n_reg;
    assign sram_d_out = sram_d_out_reg;
    assign sram_d_oe  = sram_d_oe_reg;
    assign cpu_rdata  = cpu_rdata_reg;
    assign vid_rdata  = vid_rdata_reg;
    assign cpu_ack    = cpu_ack_reg;
    assign vid_ack    = vid_ack_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Drives sram_arbiter with directed scenarios and randomized traffic. A
// behavioural SRAM device answers the DUT pins; a separate reference model
// schedules, per granted access, the expected pin values for each future cycle
// and compares the DUT against them every cycle.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int AC  = 2;
    localparam int MVR = 4;
    localparam int NS  = 32;

    logic        clk_chipset;
    logic        rst_n;
    logic        cpu_req, cpu_we, vid_req;
    logic [20:0] cpu_addr, vid_addr;
    logic [7:0]  cpu_wdata, sram_d_in;
    logic [7:0]  cpu_rdata, vid_rdata, sram_d_out;
    logic        cpu_ack, vid_ack, SRAM_WE_n, sram_d_oe, busy;
    logic [20:0] SRAM_ADDR;

    sram_arbiter #(.ACCESS_CYCLES(AC), .MAX_VIDEO_RUN(MVR)) dut (
        .clk_chipset(clk_chipset), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_n(SRAM_WE_n), .sram_d_in(sram_d_in),
        .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe), .busy(busy)
    );

    initial clk_chipset = 1'b0;
    always #10 clk_chipset = ~clk_chipset;

    // staged inputs, applied just after the next rising edge
    logic        nxt_rst_n, nxt_cpu_req, nxt_cpu_we, nxt_vid_req;
    logic [20:0] nxt_cpu_addr, nxt_vid_addr;
    logic [7:0]  nxt_cpu_wdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    string ack_log = "";

    bit [7:0] phys[int];    // SRAM device contents
    bit [7:0] refmem[int];  // reference model's view of memory

    // per-future-cycle expectations
    bit          s_busy[NS], s_we_low[NS], s_oe[NS], s_cack[NS], s_vack[NS], s_rst[NS];
    bit          s_set_addr[NS], s_set_dout[NS], s_set_crd[NS], s_set_vrd[NS];
    logic [20:0] s_addr[NS];
    logic [7:0]  s_dout[NS], s_crd[NS], s_vrd[NS];
    logic [20:0] h_addr;
    logic [7:0]  h_dout, h_crd, h_vrd;
    int          free_at = 0;
    int          vid_run = 0;
    bit          armed = 1'b0;
    bit          exp_cack_now = 1'b0;

    function automatic logic [7:0] def_byte(int a);
        return 8'((a ^ (a >> 8) ^ (a >> 16)) + 8'h5A);
    endfunction

    function automatic logic [7:0] phys_rd(int a);
        return phys.exists(a) ? phys[a] : def_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(int a);
        return refmem.exists(a) ? refmem[a] : def_byte(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_slot(input int i);
        s_busy[i] = 0; s_we_low[i] = 0; s_oe[i] = 0; s_cack[i] = 0; s_vack[i] = 0; s_rst[i] = 0;
        s_set_addr[i] = 0; s_set_dout[i] = 0; s_set_crd[i] = 0; s_set_vrd[i] = 0;
    endtask

    task automatic schedule_read(input logic [20:0] a, input bit to_cpu);
        int i;
        for (int k = 1; k <= AC; k++) s_busy[(cyc + k) % NS] = 1;
        s_set_addr[(cyc + 1) % NS] = 1;
        s_addr[(cyc + 1) % NS] = a;
        i = (cyc + AC + 1) % NS;
        if (to_cpu) begin
            s_cack[i] = 1; s_set_crd[i] = 1; s_crd[i] = ref_rd(int'(a));
        end else begin
            s_vack[i] = 1; s_set_vrd[i] = 1; s_vrd[i] = ref_rd(int'(a));
        end
        free_at = cyc + AC + 1;
    endtask

    task automatic schedule_write(input logic [20:0] a, input logic [7:0] d);
        for (int k = 1; k <= AC + 1; k++) begin
            s_busy[(cyc + k) % NS] = 1;
            s_oe[(cyc + k) % NS] = 1;
            if (k >= 2 && k <= AC) s_we_low[(cyc + k) % NS] = 1;
        end
        s_set_addr[(cyc + 1) % NS] = 1; s_addr[(cyc + 1) % NS] = a;
        s_set_dout[(cyc + 1) % NS] = 1; s_dout[(cyc + 1) % NS] = d;
        s_cack[(cyc + AC + 2) % NS] = 1;
        refmem[int'(a)] = d;
        free_at = cyc + AC + 2;
    endtask

    // One clock cycle: apply staged inputs, run the SRAM device, compare the
    // DUT against the model's expectations and advance the model.
    task automatic cycle();
        int sl;
        bit ce, gv, gc;
        @(posedge clk_chipset);
        cyc++;
        #1;
        rst_n = nxt_rst_n; cpu_req = nxt_cpu_req; cpu_we = nxt_cpu_we;
        cpu_addr = nxt_cpu_addr; cpu_wdata = nxt_cpu_wdata;
        vid_req = nxt_vid_req; vid_addr = nxt_vid_addr;
        @(negedge clk_chipset);
        if (SRAM_WE_n === 1'b0 && sram_d_oe === 1'b1) phys[int'(SRAM_ADDR)] = sram_d_out;
        sram_d_in = phys_rd(int'(SRAM_ADDR));
        if (cpu_ack === 1'b1) ack_log = {ack_log, "C"};
        if (vid_ack === 1'b1) ack_log = {ack_log, "V"};

        sl = cyc % NS;
        exp_cack_now = 1'b0;
        if (armed) begin
            if (s_rst[sl]) begin
                h_addr = '0; h_dout = '0; h_crd = '0; h_vrd = '0;
            end
            if (s_set_addr[sl]) h_addr = s_addr[sl];
            if (s_set_dout[sl]) h_dout = s_dout[sl];
            if (s_set_crd[sl])  h_crd  = s_crd[sl];
            if (s_set_vrd[sl])  h_vrd  = s_vrd[sl];
            chk("sram_addr",  32'(SRAM_ADDR),  32'(h_addr));
            chk("sram_we_n",  32'(SRAM_WE_n),  32'(!s_we_low[sl]));
            chk("sram_d_oe",  32'(sram_d_oe),  32'(s_oe[sl]));
            chk("sram_d_out", 32'(sram_d_out), 32'(h_dout));
            chk("busy",       32'(busy),       32'(s_busy[sl]));
            chk("cpu_ack",    32'(cpu_ack),    32'(s_cack[sl]));
            chk("vid_ack",    32'(vid_ack),    32'(s_vack[sl]));
            chk("cpu_rdata",  32'(cpu_rdata),  32'(h_crd));
            chk("vid_rdata",  32'(vid_rdata),  32'(h_vrd));
            exp_cack_now = s_cack[sl];
        end
        clear_slot(sl);

        if (rst_n === 1'b0) begin
            for (int i = 0; i < NS; i++) clear_slot(i);
            s_rst[(cyc + 1) % NS] = 1;
            free_at = cyc + 1;
            vid_run = 0;
            armed = 1'b1;
        end else if (armed && cyc >= free_at) begin
            ce = cpu_req && !exp_cack_now;
            gv = vid_req && (!ce || vid_run != MVR);
            gc = ce && !gv;
            if (gc || !cpu_req) vid_run = 0;
            else if (gv && vid_run < MVR) vid_run++;
            if (gv) schedule_read(vid_addr, 1'b0);
            else if (gc) begin
                if (cpu_we) schedule_write(cpu_addr, cpu_wdata);
                else schedule_read(cpu_addr, 1'b1);
            end
        end
    endtask

    task automatic go_idle();
        int n = 0;
        nxt_cpu_req = 0; nxt_vid_req = 0;
        do begin cycle(); n++; end while (busy !== 1'b0 && n < 40);
        chk("idle_timeout", 32'(busy), 32'd0);
        cycle();
    endtask

    function automatic logic [20:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? 21'($urandom) : 21'($urandom_range(0, 63));
    endfunction

    initial begin
        int first_ack, second_ack, nacks;
        rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 0; vid_addr = '0; sram_d_in = '0;
        nxt_rst_n = 0; nxt_cpu_req = 0; nxt_cpu_we = 0; nxt_cpu_addr = '0;
        nxt_cpu_wdata = '0; nxt_vid_req = 0; nxt_vid_addr = '0;
        h_addr = '0; h_dout = '0; h_crd = '0; h_vrd = '0;
        for (int i = 0; i < NS; i++) clear_slot(i);

        // reset state
        cycle(); cycle();
        chk("rst_we_n", 32'(SRAM_WE_n), 32'd1);
        chk("rst_oe",   32'(sram_d_oe), 32'd0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_busy", 32'(busy),      32'd0);
        chk("rst_crd",  32'(cpu_rdata), 32'd0);
        nxt_rst_n = 1;
        go_idle();

        // CPU read of the top address
        phys[21'h1FFFFF] = 8'hA5; refmem[21'h1FFFFF] = 8'hA5;
        nxt_cpu_req = 1; nxt_cpu_we = 0; nxt_cpu_addr = 21'h1FFFFF;
        cycle();                     // t
        cycle();                     // t+1
        chk("rd_addr", 32'(SRAM_ADDR), 32'h1FFFFF);
        chk("rd_we_n", 32'(SRAM_WE_n), 32'd1);
        cycle(); cycle();            // t+3
        chk("rd_ack",   32'(cpu_ack),   32'd1);
        chk("rd_rdata", 32'(cpu_rdata), 32'hA5);
        go_idle();

        // CPU write then readback on the same held request level
        nxt_cpu_req = 1; nxt_cpu_we = 1; nxt_cpu_addr = 21'h000010; nxt_cpu_wdata = 8'h3C;
        cycle();                     // t
        nxt_cpu_wdata = 8'h99;       // ignored: access already in progress
        cycle();                     // t+1
        chk("wr_we_t1", 32'(SRAM_WE_n), 32'd1);
        chk("wr_oe_t1", 32'(sram_d_oe), 32'd1);
        chk("wr_dout",  32'(sram_d_out), 32'h3C);
        cycle();                     // t+2
        chk("wr_we_t2", 32'(SRAM_WE_n), 32'd0);
        cycle();                     // t+3
        chk("wr_we_t3", 32'(SRAM_WE_n), 32'd1);
        chk("wr_oe_t3", 32'(sram_d_oe), 32'd1);
        chk("wr_noack", 32'(cpu_ack),   32'd0);
        nxt_cpu_we = 0;
        cycle();                     // t+4
        chk("wr_ack",   32'(cpu_ack),   32'd1);
        chk("wr_oe_t4", 32'(sram_d_oe), 32'd0);
        cycle(); cycle(); cycle(); cycle();   // readback granted t+5, ack t+8
        chk("wr_readback_ack", 32'(cpu_ack),   32'd1);
        chk("wr_readback",     32'(cpu_rdata), 32'h3C);
        go_idle();

        // back-to-back video reads
        phys[0] = 8'h11; refmem[0] = 8'h11; phys[1] = 8'h22; refmem[1] = 8'h22;
        nxt_vid_req = 1; nxt_vid_addr = 21'h000000;
        cycle();
        nxt_vid_addr = 21'h000001;
        first_ack = -1; second_ack = -1; nacks = 0;
        for (int i = 0; i < 12; i++) begin
            if (nacks >= 1) nxt_vid_req = 0;
            cycle();
            if (vid_ack === 1'b1) begin
                if (nacks == 0) begin
                    first_ack = cyc;
                    chk("vid_rdata0", 32'(vid_rdata), 32'h11);
                end else if (nacks == 1) begin
                    second_ack = cyc;
                    chk("vid_rdata1", 32'(vid_rdata), 32'h22);
                end
                nacks++;
            end
        end
        chk("vid_ack_gap", 32'(second_ack - first_ack), 32'd3);
        chk("vid_ack_count", 32'(nacks), 32'd2);
        go_idle();

        // contention: both requests held high continuously
        ack_log = "";
        nxt_cpu_req = 1; nxt_cpu_we = 0; nxt_vid_req = 1;
        for (int i = 0; i < 120 && ack_log.len() < 10; i++) begin
            nxt_cpu_addr = rnd_addr(); nxt_vid_addr = rnd_addr();
            cycle();
        end
        n_cmp++;
        if (ack_log != "VVVVCVVVVC") begin
            n_fail++;
            $display("FAIL grant_order: got %s expected VVVVCVVVVC", ack_log);
        end
        go_idle();

        // reset in the middle of a write strobe
        nxt_cpu_req = 1; nxt_cpu_we = 1; nxt_cpu_addr = 21'h001000; nxt_cpu_wdata = 8'h77;
        cycle();                     // t
        cycle();                     // t+1
        nxt_rst_n = 0; nxt_cpu_req = 0;
        cycle();                     // t+2, reset sampled at its end
        chk("abort_we_low", 32'(SRAM_WE_n), 32'd0);
        nxt_rst_n = 1;
        cycle();                     // t+3
        chk("abort_we_n", 32'(SRAM_WE_n), 32'd1);
        chk("abort_oe",   32'(sram_d_oe), 32'd0);
        chk("abort_busy", 32'(busy),      32'd0);
        chk("abort_ack",  32'(cpu_ack),   32'd0);
        cycle();                     // t+4
        chk("abort_ack_late", 32'(cpu_ack), 32'd0);
        nxt_cpu_req = 1; nxt_cpu_we = 0; nxt_cpu_addr = 21'h1FFFFF;
        cycle(); cycle(); cycle(); cycle();
        chk("post_rst_ack",   32'(cpu_ack),   32'd1);
        chk("post_rst_rdata", 32'(cpu_rdata), 32'hA5);
        go_idle();

        // randomized traffic with varying video load
        for (int i = 0; i < 3000; i++) begin
            nxt_cpu_we    = 1'($urandom_range(0, 1));
            nxt_cpu_addr  = rnd_addr();
            nxt_cpu_wdata = 8'($urandom);
            nxt_vid_addr  = rnd_addr();
            nxt_vid_req   = ($urandom_range(0, 9) < (3 + 3 * (i / 1000)));
            if (cpu_req !== 1'b1) nxt_cpu_req = ($urandom_range(0, 2) == 0);
            else if (cpu_ack === 1'b1) nxt_cpu_req = 1'($urandom_range(0, 1));
            else nxt_cpu_req = 1'b1;
            cycle();
        end
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ACCESS_CYCLES, default 2, meaning the number of clk_chipset cycles an SRAM address is held per access (legal range 2..15).
REQ-002 The block SHALL have parameter MAX_VIDEO_RUN, default 4, meaning consecutive video grants allowed while the CPU is waiting (legal range 1..15).
REQ-003 clk_chipset  input  1  system clock (50 MHz); all logic is on its rising edge.
REQ-004 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-005 cpu_req  input  1  CPU request; a level held high until cpu_ack is seen.
REQ-006 cpu_we  input  1  1 = write, 0 = read; sampled at grant.
REQ-007 cpu_addr  input  21  CPU byte address; sampled at grant.
REQ-008 cpu_wdata  input  8  CPU write data; sampled at grant.
REQ-009 cpu_rdata  output  8  read data; valid while cpu_ack=1 after a read, and held until the next CPU read completes.
REQ-010 cpu_ack  output  1  one-cycle completion pulse.
REQ-011 vid_req  input  1  video fetch request (read-only); a level.
REQ-012 vid_addr  input  21  video byte address; sampled at grant.
REQ-013 vid_rdata  output  8  video read data; valid with vid_ack and held afterwards.
REQ-014 vid_ack  output  1  one-cycle completion pulse.
REQ-015 SRAM_ADDR  output  21  SRAM address, registered.
REQ-016 SRAM_WE_n  output  1  SRAM write enable, active-low, registered.
REQ-017 sram_d_in  input  8  SRAM data bus input.
REQ-018 sram_d_out  output  8  SRAM write data, registered.
REQ-019 sram_d_oe  output  1  data bus drive enable, registered; the tristate buffer lives at top level.
REQ-020 busy  output  1  high whenever the state is not IDLE.

Function
REQ-021 The state machine SHALL have the states IDLE, READ, WRITE and TURN, with these transitions:
- IDLE goes to READ on any read grant.
- IDLE goes to WRITE on a CPU write grant.
- READ and WRITE each last exactly ACCESS_CYCLES cycles.
- READ returns to IDLE.
- WRITE goes to TURN, which lasts one cycle and then returns to IDLE.
REQ-022 Arbitration SHALL occur only in IDLE, and a requester whose ack is high in that cycle SHALL be ignored.
REQ-023 When both requests are eligible, video SHALL win unless vid_run equals MAX_VIDEO_RUN, in which case the CPU SHALL win.
REQ-024 vid_run SHALL behave as follows:
- increments (saturating at MAX_VIDEO_RUN) on a video grant made while cpu_req=1;
- clears on a CPU grant;
- clears in any IDLE cycle with cpu_req=0.
REQ-025 Read timing SHALL be as follows:
- grant in IDLE at cycle t;
- SRAM_ADDR = the granted address and SRAM_WE_n = 1 during cycles t+1..t+ACCESS_CYCLES;
- sram_d_in is captured at the end of cycle t+ACCESS_CYCLES;
- the ack and the rdata update occur in cycle t+ACCESS_CYCLES+1.
REQ-026 Write timing SHALL be as follows:
- grant at cycle t;
- sram_d_oe = 1 and the address and data are held from t+1 through t+ACCESS_CYCLES+1;
- SRAM_WE_n = 1 at t+1, 0 for t+2..t+ACCESS_CYCLES, and 1 in TURN (t+ACCESS_CYCLES+1);
- sram_d_oe = 0 from t+ACCESS_CYCLES+2;
- cpu_ack occurs at t+ACCESS_CYCLES+2.
REQ-027 A new grant MAY be issued in the same IDLE cycle in which an ack is asserted, giving back-to-back accesses with no idle cycle.
REQ-028 SRAM_WE_n SHALL never be low while sram_d_oe = 0, and SRAM_ADDR SHALL never change while SRAM_WE_n = 0.
REQ-029 Changes to request inputs while the block is not in IDLE SHALL have no effect on the access in progress.
REQ-030 With no request in IDLE, SRAM_ADDR SHALL hold its last value, with SRAM_WE_n = 1 and sram_d_oe = 0.

Reset
REQ-031 While rst_n = 0 at a clock edge, the block SHALL produce:
- state = IDLE;
- SRAM_WE_n = 1;
- sram_d_oe = 0;
- SRAM_ADDR, sram_d_out, cpu_rdata and vid_rdata = 0;
- cpu_ack, vid_ack and busy = 0;
- vid_run = 0.
REQ-032 A reset asserted mid-access SHALL abort the access with no ack, and SRAM_WE_n SHALL go high on that same edge.

Verification
REQ-033 CPU read: SRAM model holds 0xA5 at 0x1F_FFFF; cpu_req=1, cpu_we=0, cpu_addr=0x1F_FFFF granted at t -> cpu_ack=1 and cpu_rdata=0xA5 at t+3 (ACCESS_CYCLES=2).
REQ-034 CPU write: cpu_addr=0x00_0010, cpu_wdata=0x3C granted at t -> SRAM_WE_n low only at t+2; sram_d_oe high t+1..t+3; cpu_ack at t+4; a readback returns 0x3C.
REQ-035 Contention: vid_req and cpu_req both held high continuously -> grant sequence V,V,V,V,C,V,V,V,V,C; no ack is ever missed.
REQ-036 Reset mid-write: rst_n=0 in the cycle SRAM_WE_n=0 -> next cycle SRAM_WE_n=1, sram_d_oe=0, busy=0, no cpu_ack; a subsequent read completes normally.
REQ-037 Back-to-back video reads to 0x000000 then 0x000001 -> second grant in the first vid_ack cycle; vid_ack pulses exactly 3 cycles apart.
